// File: rtl/thermometer_spi_ctrl.sv
// SPI master and sample scheduler for a TMP125-style thermometer.
// Optional framing check on the sign-extension bit is enabled by defining THERM_FAULT_EN.
//
// state | meaning
// IDLE  | bus quiet, waiting for an auto or demand trigger
// SETUP | cs_n low, sclk high, CLK_DIV cycles before the first falling edge
// SHIFT | 16 sclk periods (low then high), sampling on each rising edge
// HOLD  | sclk high, cs_n low for CLK_DIV cycles after the last rising edge
// DONE  | cs_n high, result presented, pending trigger restarts immediately
module thermometer_spi_ctrl #(
    parameter int CLK_DIV       = 2,
    parameter int SAMPLE_PERIOD = 200
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_enable,
    input  logic       i_read_req,
    output logic       o_spi_clk,
    output logic       o_spi_cs_n,
    output logic       o_spi_si,
    input  logic       i_spi_so,
    output logic [9:0] o_temp,
    output logic       o_temp_valid,
    output logic       o_busy,
    output logic       o_fault
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int PW = $clog2(SAMPLE_PERIOD);
`ifdef THERM_FAULT_EN
    localparam int SW = 16;
`else
    // Without the framing check bit 15 is never looked at, so it is shifted out.
    localparam int SW = 15;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_HOLD,
        S_DONE
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [3:0]      r_bits;
    logic [SW-1:0]   r_shreg;
    logic [PW-1:0]   r_period;
    logic            r_pend;
    logic            r_sclk;
    logic            r_cs_n;
    logic [9:0]      r_temp;
    logic            r_valid;
    logic            r_busy;
    logic            w_auto;
    logic            w_trig;

    assign w_auto = i_enable && (r_period == PW'(SAMPLE_PERIOD - 1));
    assign w_trig = w_auto || i_read_req;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_period <= '0;
        end else if (!i_enable || w_auto) begin
            r_period <= '0;
        end else begin
            r_period <= r_period + 1'b1;
        end
    end

`ifdef THERM_FAULT_EN
    logic r_fault;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_bits  <= '0;
            r_shreg <= '0;
            r_pend  <= 1'b0;
            r_sclk  <= 1'b1;
            r_cs_n  <= 1'b1;
            r_temp  <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
`ifdef THERM_FAULT_EN
            r_fault <= 1'b0;
`endif
        end else begin
            r_valid <= 1'b0;
`ifdef THERM_FAULT_EN
            r_fault <= 1'b0;
`endif
            // DONE consumes triggers directly, so only mid-transaction ones are deferred.
            if (w_trig && r_state != S_IDLE && r_state != S_DONE) begin
                r_pend <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_trig) begin
                        r_state <= S_SETUP;
                        r_cs_n  <= 1'b0;
                        r_sclk  <= 1'b1;
                        r_busy  <= 1'b1;
                        r_cnt   <= CW'(CLK_DIV - 1);
                    end
                end
                S_SETUP: begin
                    if (r_cnt == '0) begin
                        r_state <= S_SHIFT;
                        r_sclk  <= 1'b0;
                        r_bits  <= 4'd15;
                        r_cnt   <= CW'(CLK_DIV - 1);
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_SHIFT: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else if (!r_sclk) begin
                        r_sclk  <= 1'b1;
                        r_shreg <= {r_shreg[SW-2:0], i_spi_so};
                        r_cnt   <= CW'(CLK_DIV - 1);
                    end else if (r_bits == 4'd0) begin
                        r_state <= S_HOLD;
                        r_cnt   <= CW'(CLK_DIV - 1);
                    end else begin
                        r_sclk <= 1'b0;
                        r_bits <= r_bits - 4'd1;
                        r_cnt  <= CW'(CLK_DIV - 1);
                    end
                end
                S_HOLD: begin
                    if (r_cnt == '0) begin
                        r_state <= S_DONE;
                        r_cs_n  <= 1'b1;
`ifdef THERM_FAULT_EN
                        if (r_shreg[15]) begin
                            r_fault <= 1'b1;
                        end else begin
                            r_temp  <= r_shreg[14:5];
                            r_valid <= 1'b1;
                        end
`else
                        r_temp  <= r_shreg[14:5];
                        r_valid <= 1'b1;
`endif
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_DONE: begin
                    if (r_pend || w_trig) begin
                        r_state <= S_SETUP;
                        r_cs_n  <= 1'b0;
                        r_sclk  <= 1'b1;
                        r_pend  <= 1'b0;
                        r_cnt   <= CW'(CLK_DIV - 1);
                    end else begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cs_n  <= 1'b1;
                    r_sclk  <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_spi_clk    = r_sclk;
    assign o_spi_cs_n   = r_cs_n;
    assign o_spi_si     = 1'b0;
    assign o_temp       = r_temp;
    assign o_temp_valid = r_valid;
    assign o_busy       = r_busy;
`ifdef THERM_FAULT_EN
    assign o_fault      = r_fault;
`else
    assign o_fault      = 1'b0;
`endif

endmodule

// File: tb/tb_thermometer_spi_ctrl.sv
// Scoreboard bench for thermometer_spi_ctrl: transaction-level timing model plus a thermometer model.
module tb_thermometer_spi_ctrl;

    localparam int CD  = 2;
    localparam int SP  = 200;
    localparam int TXN = 34 * CD + 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b0;
    logic       req = 1'b0;
    logic       so  = 1'b0;
    logic       spi_clk, cs_n, si, valid, busy, fault;
    logic [9:0] temp;

    always #5 clk = ~clk;

    thermometer_spi_ctrl #(.CLK_DIV(CD), .SAMPLE_PERIOD(SP)) dut (
        .i_clk(clk), .i_rst(rst), .i_enable(en), .i_read_req(req),
        .o_spi_clk(spi_clk), .o_spi_cs_n(cs_n), .o_spi_si(si), .i_spi_so(so),
        .o_temp(temp), .o_temp_valid(valid), .o_busy(busy), .o_fault(fault)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int vcount = 0;
    int m_per = 0, m_pend = 0, m_start = -1, m_done = -1;
    int q_cyc[$];
    logic [15:0] q_word[$];
    logic [9:0]  m_last = '0;
    logic [15:0] cur_word = '0, force_word = '0, w = '0;
    bit   use_force = 0;
    bit   auto_t, trig;
    int   rises = 0;
    int   vc0;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Transaction-level model: one transaction lasts TXN cycles from acceptance to result,
    // any triggers while it runs collapse into a single follow-on started in the result cycle.
    always @(posedge clk) begin
        if (rst) begin
            m_per = 0; m_pend = 0; m_start = -1; m_done = -1; m_last = '0;
            q_cyc.delete(); q_word.delete();
        end else begin
            auto_t = en && (m_per == SP - 1);
            m_per  = en ? (m_per + 1) % SP : 0;
            trig   = auto_t || req;
            if (cyc >= m_done) begin
                if ((cyc == m_done && m_pend != 0) || trig) begin
                    m_start = cyc;
                    m_done  = cyc + TXN;
                    m_pend  = 0;
                    q_cyc.push_back(m_done);
                end
            end else if (trig) begin
                m_pend = 1;
            end
        end
        cyc++;
    end

    // Thermometer: presents the next word bit after each rising sclk, MSB first.
    always @(negedge cs_n) begin
        cur_word = use_force ? force_word : 16'($urandom);
        q_word.push_back(cur_word);
        rises = 0;
        so = cur_word[15];
    end
    always @(posedge spi_clk) if (cs_n == 1'b0) begin
        rises++;
        so = (rises < 16) ? cur_word[15 - rises] : 1'b0;
    end
    always @(posedge cs_n) if (!rst) chk("sclk_rises", rises, 16);

    always @(negedge clk) begin
        #1;
        if (!rst) begin
            chk("busy", busy, int'(cyc > m_start && cyc <= m_done));
            chk("cs_n", cs_n, int'(!(cyc > m_start && cyc < m_done)));
            if (!(cyc > m_start && cyc < m_done)) chk("sclk_idle", spi_clk, 1);
            chk("si", si, 0);
            if (q_cyc.size() > 0 && q_cyc[0] == cyc) begin
                void'(q_cyc.pop_front());
                chk("word_queued", int'(q_word.size() > 0), 1);
                w = (q_word.size() > 0) ? q_word.pop_front() : 16'h0;
`ifdef THERM_FAULT_EN
                if (w[15]) begin
                    chk("fault", fault, 1);
                    chk("valid_on_fault", valid, 0);
                    chk("temp_hold", temp, m_last);
                end else
`endif
                begin
                    chk("valid", valid, 1);
                    chk("temp", temp, w[14:5]);
                    chk("no_fault", fault, 0);
                    m_last = w[14:5];
                end
            end else begin
                chk("spurious_valid", valid, 0);
                chk("spurious_fault", fault, 0);
            end
            if (valid) vcount++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_req();
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_sclk"}, spi_clk, 1);
        chk({tag, "_cs_n"}, cs_n, 1);
        chk({tag, "_si"}, si, 0);
        chk({tag, "_temp"}, temp, 0);
        chk({tag, "_valid"}, valid, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_fault"}, fault, 0);
    endtask

    initial begin
        tick(3);
        reset_checks("por");
        rst = 1'b0;
        tick(20);
        rst = 1'b1;
        #1 reset_checks("idle_rst");
        tick(2);
        rst = 1'b0;
        tick(1000);

        use_force = 1; force_word = 16'h0C80; vc0 = vcount;
        pulse_req(); tick(TXN + 5);
        chk("demand_temp", temp, 10'h064);
        chk("demand_count", vcount - vc0, 1);

        force_word = 16'h7F60; vc0 = vcount;
        pulse_req(); tick(TXN + 5);
        chk("neg_temp", temp, 10'h3FB);
        chk("neg_count", vcount - vc0, 1);

        use_force = 0; vc0 = vcount;
        en = 1'b1; tick(600); en = 1'b0; tick(300);
        chk("auto_count", vcount - vc0, 3);

        vc0 = vcount;
        en = 1'b1; tick(190);
        pulse_req(); tick(5);
        pulse_req(); tick(8);
        pulse_req(); en = 1'b0;
        tick(250);
        chk("collision_count", vcount - vc0, 2);

        pulse_req();
        for (int i = 0; i < 200 && rises < 7; i++) @(negedge clk);
        chk("edges_before_rst", rises, 7);
        rst = 1'b1;
        #1;
        chk("abort_cs_n", cs_n, 1);
        chk("abort_sclk", spi_clk, 1);
        chk("abort_valid", valid, 0);
        chk("abort_temp", temp, 0);
        tick(2); rst = 1'b0; vc0 = vcount;
        tick(100);
        chk("abort_no_valid", vcount - vc0, 0);

        use_force = 1; force_word = 16'h8C80; vc0 = vcount;
        pulse_req(); tick(TXN + 5);
`ifdef THERM_FAULT_EN
        chk("fault_temp", temp, 0);
        chk("fault_count", vcount - vc0, 0);
`else
        chk("nocheck_temp", temp, 10'h064);
        chk("nocheck_count", vcount - vc0, 1);
`endif

        use_force = 0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 299) == 0) en = ~en;
            req = ($urandom_range(0, 79) == 0);
            @(negedge clk);
        end
        req = 1'b0; en = 1'b0;
        tick(200);
        chk("timing_queue_drained", q_cyc.size(), 0);
        chk("word_queue_drained", q_word.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
